// File: rtl/wave_gen_pkg.sv
// Shared types and reset defaults for the multi-channel wave generator.
// Burst support is compiled in with WAVE_GEN_BURST_EN.
package wave_gen_pkg;

  // Internal datapath widths; the top-level CNT_W/BURST_W ports may be narrower.
  localparam int WG_CNT_W   = 16;
  localparam int WG_BURST_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } chan_state_e;

  typedef struct packed {
    logic [WG_CNT_W-1:0]   period;
    logic [WG_CNT_W-1:0]   high;
    logic [WG_CNT_W-1:0]   phase;
    logic [WG_BURST_W-1:0] burst;
  } wave_cfg_t;

  localparam wave_cfg_t   WG_CFG_RESET   = '0;
  localparam chan_state_e WG_STATE_RESET = ST_IDLE;

endpackage

// File: rtl/multi_channel_wave_generator_if.sv
// Configuration write port of the multi-channel wave generator.
interface multi_channel_wave_generator_if #(
  parameter int NCH     = 4,
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  // A write transfers on every rising clock edge where cfg_valid && cfg_ready;
  // cfg_ready depends only on cfg_ch and registered state, never on cfg_valid.
  logic               cfg_valid;
  logic               cfg_ready;
  logic [CH_W-1:0]    cfg_ch;
  logic [CNT_W-1:0]   cfg_period;
  logic [CNT_W-1:0]   cfg_high;
  logic [CNT_W-1:0]   cfg_phase;
  logic [BURST_W-1:0] cfg_burst;

  modport master (
    output cfg_valid, cfg_ch, cfg_period, cfg_high, cfg_phase, cfg_burst,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_period, cfg_high, cfg_phase, cfg_burst,
    output cfg_ready
  );
endinterface

// File: rtl/wave_gen_channel.sv
// One waveform channel: counter, IDLE/RUN/HALT FSM, shadow/pending config and
// registered outputs. HALT and the burst counter exist only with WAVE_GEN_BURST_EN.
module wave_gen_channel
  import wave_gen_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        sync_start,
  input  logic        wr_en,
  input  wave_cfg_t   wr_cfg,
  output logic        pending,
  output logic        wave_out,
  output logic        period_tick,
  output logic        done,
  output chan_state_e state_dbg
);
  chan_state_e         state_q, state_d;
  wave_cfg_t           act_q, act_d, shd_q, shd_d, eff;
  logic                pend_q, pend_d;
  logic [WG_CNT_W-1:0] cnt_q, cnt_d, start_cnt;
  logic                wave_q, wave_d, tick_q, tick_d, done_q, done_d;
  logic                wrap, apply;
`ifdef WAVE_GEN_BURST_EN
  logic [WG_BURST_W-1:0] bcnt_q, bcnt_d;
  logic                  last_period;
`else
  logic                  unused_burst;
  assign unused_burst = ^act_q.burst;
`endif

  assign wrap      = (state_q == ST_RUN) && (cnt_q == act_q.period);
  assign apply     = pend_q && (sync_start || wrap || (state_q != ST_RUN));
  // Values in force after this edge; the start phase is clamped against them.
  assign eff       = apply ? shd_q : act_q;
  assign start_cnt = (eff.phase > eff.period) ? '0 : eff.phase;
`ifdef WAVE_GEN_BURST_EN
  assign last_period = (act_q.burst != '0) && (bcnt_q == act_q.burst - WG_BURST_W'(1));
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    shd_d   = shd_q;
    pend_d  = pend_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    wave_d  = 1'b0;
`ifdef WAVE_GEN_BURST_EN
    bcnt_d  = bcnt_q;
`endif
    if (apply) begin
      act_d  = shd_q;
      pend_d = 1'b0;
    end
    // A write landing with an apply stays pending for the next apply event.
    if (wr_en) begin
      shd_d  = wr_cfg;
      pend_d = 1'b1;
    end
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_RUN;
          cnt_d   = start_cnt;
`ifdef WAVE_GEN_BURST_EN
          bcnt_d  = '0;
`endif
        end
        ST_RUN: begin
          if (sync_start) begin
            cnt_d  = start_cnt;
`ifdef WAVE_GEN_BURST_EN
            bcnt_d = '0;
`endif
          end else if (wrap) begin
            cnt_d  = '0;
            tick_d = 1'b1;
`ifdef WAVE_GEN_BURST_EN
            if (last_period) begin
              state_d = ST_HALT;
              done_d  = 1'b1;
            end else if (act_q.burst != '0) begin
              bcnt_d = bcnt_q + WG_BURST_W'(1);
            end
`endif
          end else begin
            cnt_d = cnt_q + WG_CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
    wave_d = (state_d == ST_RUN) && (cnt_d < act_d.high);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WG_STATE_RESET;
      act_q   <= WG_CFG_RESET;
      shd_q   <= WG_CFG_RESET;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      wave_q  <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef WAVE_GEN_BURST_EN
      bcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      shd_q   <= shd_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      wave_q  <= wave_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
`ifdef WAVE_GEN_BURST_EN
      bcnt_q  <= bcnt_d;
`endif
    end
  end

  assign pending     = pend_q;
  assign wave_out    = wave_q;
  assign period_tick = tick_q;
  assign done        = done_q;
  assign state_dbg   = state_q;
endmodule

// File: rtl/multi_channel_wave_generator.sv
// NCH independent programmable waveform channels behind one config write port.
// Define WAVE_GEN_BURST_EN to enable burst mode (HALT state and done pulses).
module multi_channel_wave_generator
  import wave_gen_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int CNT_W   = WG_CNT_W,
  parameter int BURST_W = WG_BURST_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NCH-1:0]               enable,
  input  logic                         sync_start,
  multi_channel_wave_generator_if.slave cfg,
  output logic [NCH-1:0]               wave_out,
  output logic [NCH-1:0]               period_tick,
  output logic [NCH-1:0]               done,
  output logic [2*NCH-1:0]             chan_state_dbg
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]     pending;
  logic [NCH-1:0]     wr_en;
  logic               ready_c;
  logic [CNT_W-1:0]   in_period, in_high, in_phase;
  logic [BURST_W-1:0] in_burst;
  wave_cfg_t          wr_cfg;

  assign in_period     = cfg.cfg_period;
  assign in_high       = cfg.cfg_high;
  assign in_phase      = cfg.cfg_phase;
  assign in_burst      = cfg.cfg_burst;
  assign wr_cfg.period = WG_CNT_W'(in_period);
  assign wr_cfg.high   = WG_CNT_W'(in_high);
  assign wr_cfg.phase  = WG_CNT_W'(in_phase);
  assign wr_cfg.burst  = WG_BURST_W'(in_burst);

  // Addresses with no channel behind them stay ready so writes drain and drop.
  always_comb begin
    ready_c = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (cfg.cfg_ch == CH_W'(i)) ready_c = !pending[i];
    end
  end
  assign cfg.cfg_ready = ready_c;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    chan_state_e st;

    assign wr_en[g] = cfg.cfg_valid && !pending[g] && (cfg.cfg_ch == CH_W'(g));

    wave_gen_channel u_ch (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable[g]),
      .sync_start  (sync_start),
      .wr_en       (wr_en[g]),
      .wr_cfg      (wr_cfg),
      .pending     (pending[g]),
      .wave_out    (wave_out[g]),
      .period_tick (period_tick[g]),
      .done        (done[g]),
      .state_dbg   (st)
    );

    assign chan_state_dbg[2*g +: 2] = st;
  end
endmodule

// File: tb/tb_multi_channel_wave_generator.sv
// Self-checking bench for multi_channel_wave_generator: directed scenarios plus
// randomized traffic checked against a position-arithmetic reference model.
module tb_multi_channel_wave_generator;
  localparam int NCH     = 3;
  localparam int CNT_W   = 16;
  localparam int BURST_W = 8;
  localparam int CH_W    = 2;
`ifdef WAVE_GEN_BURST_EN
  localparam bit BURST_ON = 1'b1;
`else
  localparam bit BURST_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [NCH-1:0]   enable;
  logic             sync_start;
  logic [NCH-1:0]   wave_out, period_tick, done;
  logic [2*NCH-1:0] chan_state_dbg;

  int pass_cnt  = 0;
  int check_cnt = 0;

  logic [1:0] exp_q[$];

  // Reference model: each running channel is at position (base+el) mod (P+1).
  bit     m_run[NCH], m_halt[NCH], m_pend[NCH];
  int     a_p[NCH], a_h[NCH], a_ph[NCH], a_n[NCH];
  int     s_p[NCH], s_h[NCH], s_ph[NCH], s_n[NCH];
  longint m_base[NCH], m_el[NCH];
  int     m_wraps[NCH];
  logic [NCH-1:0] exp_wave, exp_tick, exp_done;

  multi_channel_wave_generator_if #(.NCH(NCH), .CNT_W(CNT_W), .BURST_W(BURST_W)) cfg_if ();

  multi_channel_wave_generator #(.NCH(NCH), .CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .sync_start     (sync_start),
    .cfg            (cfg_if),
    .wave_out       (wave_out),
    .period_tick    (period_tick),
    .done           (done),
    .chan_state_dbg (chan_state_dbg)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        m_run[c] = 0; m_halt[c] = 0; m_pend[c] = 0;
        a_p[c] = 0; a_h[c] = 0; a_ph[c] = 0; a_n[c] = 0;
        s_p[c] = 0; s_h[c] = 0; s_ph[c] = 0; s_n[c] = 0;
        m_base[c] = 0; m_el[c] = 0; m_wraps[c] = 0;
      end
      exp_wave = '0; exp_tick = '0; exp_done = '0;
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      bit running, wrap_now, acc;
      int old_n;
      longint pos;
      running  = m_run[c] && !m_halt[c];
      pos      = running ? (m_base[c] + m_el[c]) % (a_p[c] + 1) : 0;
      wrap_now = running && (pos == a_p[c]);
      acc      = cfg_if.cfg_valid && (int'(cfg_if.cfg_ch) == c) && !m_pend[c];
      old_n    = a_n[c];
      if (m_pend[c] && (sync_start || wrap_now || !running)) begin
        a_p[c] = s_p[c]; a_h[c] = s_h[c]; a_ph[c] = s_ph[c]; a_n[c] = s_n[c];
        m_pend[c] = 0;
      end
      if (acc) begin
        s_p[c] = int'(cfg_if.cfg_period); s_h[c] = int'(cfg_if.cfg_high);
        s_ph[c] = int'(cfg_if.cfg_phase); s_n[c] = int'(cfg_if.cfg_burst);
        m_pend[c] = 1;
      end
      exp_tick[c] = 0;
      exp_done[c] = 0;
      if (!enable[c]) begin
        m_run[c] = 0; m_halt[c] = 0;
      end else if (!m_run[c] || (!m_halt[c] && sync_start)) begin
        m_run[c] = 1; m_halt[c] = 0;
        m_base[c] = (a_ph[c] > a_p[c]) ? 0 : a_ph[c];
        m_el[c] = 0; m_wraps[c] = 0;
      end else if (m_halt[c]) begin
        m_halt[c] = 1;
      end else if (wrap_now) begin
        exp_tick[c] = 1;
        m_wraps[c]++;
        if (BURST_ON && old_n != 0 && m_wraps[c] == old_n) begin
          m_halt[c] = 1; exp_done[c] = 1;
        end else begin
          m_base[c] = 0; m_el[c] = 0;
        end
      end else begin
        m_el[c]++;
      end
      exp_wave[c] = m_run[c] && !m_halt[c] &&
                    (((m_base[c] + m_el[c]) % (a_p[c] + 1)) < a_h[c]);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = '0; sync_start = 1'b0; cfg_if.cfg_valid = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic cfg_drive(input int ch, input int p, input int h, input int ph, input int n);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_ch     = CH_W'(ch);
    cfg_if.cfg_period = CNT_W'(p);
    cfg_if.cfg_high   = CNT_W'(h);
    cfg_if.cfg_phase  = CNT_W'(ph);
    cfg_if.cfg_burst  = BURST_W'(n);
  endtask

  task automatic cfg_write(input int ch, input int p, input int h, input int ph, input int n);
    cfg_drive(ch, p, h, ph, n);
    step();
    cfg_if.cfg_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    cfg_if.cfg_ch = '0;
    #1;
    check_cnt++;
    if ({wave_out, period_tick, done} !== '0) $display("FAIL reset_outputs got=%b exp=0", {wave_out, period_tick, done});
    else pass_cnt++;
    check_cnt++;
    if (cfg_if.cfg_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", cfg_if.cfg_ready);
    else pass_cnt++;
    check_cnt++;
    if (chan_state_dbg !== '0) $display("FAIL reset_state got=%b exp=0", chan_state_dbg);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [1:0] e;
    do_reset();
    cfg_write(0, 9, 5, 0, 0);
    for (int t = 0; t < 30; t++) exp_q.push_back({(t % 10 == 0) && (t > 0), (t % 10) < 5});
    enable = 3'b001;
    step();
    for (int t = 0; t < 30; t++) begin
      e = exp_q.pop_front();
      check_cnt++;
      if ({period_tick[0], wave_out[0]} !== e) $display("FAIL basic t=%0d tick_wave=%b exp=%b", t, {period_tick[0], wave_out[0]}, e);
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_midrun_write();
    logic [1:0] e;
    do_reset();
    cfg_write(0, 9, 5, 0, 0);
    enable = 3'b001;
    step();
    for (int t = 0; t < 4; t++) step();
    cfg_drive(0, 3, 1, 0, 0);
    step();
    cfg_if.cfg_valid = 1'b0;
    #1;
    check_cnt++;
    if (cfg_if.cfg_ready !== 1'b0) $display("FAIL midrun_ready_low got=%b exp=0", cfg_if.cfg_ready);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) exp_q.push_back(2'b00);
    for (int r = 0; r < 3; r++) begin
      exp_q.push_back(2'b11);
      for (int i = 0; i < 3; i++) exp_q.push_back(2'b00);
    end
    for (int t = 0; t < 17; t++) begin
      e = exp_q.pop_front();
      check_cnt++;
      if ({period_tick[0], wave_out[0]} !== e) $display("FAIL midrun t=%0d tick_wave=%b exp=%b", t, {period_tick[0], wave_out[0]}, e);
      else pass_cnt++;
      step();
    end
    check_cnt++;
    if (cfg_if.cfg_ready !== 1'b1) $display("FAIL midrun_ready_high got=%b exp=1", cfg_if.cfg_ready);
    else pass_cnt++;
  endtask

  task automatic test_sync_phase();
    logic [2:0] ew, et;
    do_reset();
    cfg_write(0, 9, 5, 0, 0);
    cfg_write(1, 9, 5, 5, 0);
    enable = 3'b011;
    step();
    for (int t = 0; t < 7; t++) begin
      ew = {1'b0, ((t + 5) % 10) < 5, (t % 10) < 5};
      check_cnt++;
      if (wave_out !== ew) $display("FAIL sync_pre t=%0d wave=%b exp=%b", t, wave_out, ew);
      else pass_cnt++;
      step();
    end
    sync_start = 1'b1;
    step();
    sync_start = 1'b0;
    for (int u = 0; u < 20; u++) begin
      ew = {1'b0, ((u + 5) % 10) < 5, (u % 10) < 5};
      et = {1'b0, ((u + 5) % 10) == 0, (u % 10 == 0) && (u > 0)};
      check_cnt++;
      if ({wave_out, period_tick} !== {ew, et}) $display("FAIL sync_post u=%0d wave_tick=%b exp=%b", u, {wave_out, period_tick}, {ew, et});
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_boundary();
    logic [2:0] et;
    do_reset();
    cfg_write(0, 9, 0, 0, 0);
    cfg_write(1, 9, 20, 0, 0);
    cfg_write(2, 0, 1, 0, 0);
    enable = 3'b111;
    step();
    for (int t = 0; t < 25; t++) begin
      et = {t > 0, (t % 10 == 0) && (t > 0), (t % 10 == 0) && (t > 0)};
      check_cnt++;
      if ({wave_out, period_tick} !== {3'b110, et}) $display("FAIL boundary t=%0d wave_tick=%b exp=%b", t, {wave_out, period_tick}, {3'b110, et});
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_phase_clamp();
    logic [1:0] ew, et;
    do_reset();
    cfg_write(0, 9, 1, 12, 0);
    cfg_write(1, 9, 1, 9, 0);
    enable = 3'b011;
    step();
    for (int t = 0; t < 12; t++) begin
      ew = {t % 10 == 1, t % 10 == 0};
      et = {t % 10 == 1, (t % 10 == 0) && (t > 0)};
      check_cnt++;
      if ({wave_out[1:0], period_tick[1:0]} !== {ew, et}) $display("FAIL phase_clamp t=%0d wave_tick=%b exp=%b", t, {wave_out[1:0], period_tick[1:0]}, {ew, et});
      else pass_cnt++;
      step();
    end
  endtask

`ifdef WAVE_GEN_BURST_EN
  task automatic test_burst();
    int dones = 0;
    logic [2:0] e;
    do_reset();
    cfg_write(0, 4, 2, 0, 3);
    enable = 3'b001;
    step();
    for (int t = 0; t < 25; t++) begin
      e = {t == 15, (t > 0) && (t % 5 == 0) && (t <= 15), (t < 15) && ((t % 5) < 2)};
      if (done[0] === 1'b1) dones++;
      check_cnt++;
      if ({done[0], period_tick[0], wave_out[0]} !== e) $display("FAIL burst t=%0d done_tick_wave=%b exp=%b", t, {done[0], period_tick[0], wave_out[0]}, e);
      else pass_cnt++;
      step();
    end
    check_cnt++;
    if (dones !== 1) $display("FAIL burst_done_count got=%0d exp=1", dones);
    else pass_cnt++;
    enable = 3'b000;
    step();
    enable = 3'b001;
    step();
    for (int t = 0; t < 7; t++) begin
      e = {1'b0, t == 5, (t % 5) < 2};
      check_cnt++;
      if ({done[0], period_tick[0], wave_out[0]} !== e) $display("FAIL burst_restart t=%0d done_tick_wave=%b exp=%b", t, {done[0], period_tick[0], wave_out[0]}, e);
      else pass_cnt++;
      step();
    end
  endtask
`else
  task automatic test_no_burst();
    logic [2:0] e;
    do_reset();
    cfg_write(0, 4, 2, 0, 3);
    enable = 3'b001;
    step();
    for (int t = 0; t < 25; t++) begin
      e = {1'b0, (t > 0) && (t % 5 == 0), (t % 5) < 2};
      check_cnt++;
      if ({done[0], period_tick[0], wave_out[0]} !== e) $display("FAIL no_burst t=%0d done_tick_wave=%b exp=%b", t, {done[0], period_tick[0], wave_out[0]}, e);
      else pass_cnt++;
      step();
    end
  endtask
`endif

  task automatic test_reset_pending();
    do_reset();
    cfg_write(0, 9, 5, 0, 0);
    enable = 3'b001;
    step(); step(); step();
    cfg_drive(0, 3, 1, 0, 0);
    step();
    cfg_if.cfg_valid = 1'b0;
    #1;
    check_cnt++;
    if (cfg_if.cfg_ready !== 1'b0) $display("FAIL rst_pend_ready_low got=%b exp=0", cfg_if.cfg_ready);
    else pass_cnt++;
    reset = 1'b1;
    step();
    check_cnt++;
    if ({wave_out, period_tick, done, chan_state_dbg, cfg_if.cfg_ready} !== {{(3*NCH+2*NCH){1'b0}}, 1'b1})
      $display("FAIL rst_pend_outputs got=%b exp=ready_only", {wave_out, period_tick, done, chan_state_dbg, cfg_if.cfg_ready});
    else pass_cnt++;
    reset = 1'b0;
    step();
    for (int t = 0; t < 8; t++) begin
      check_cnt++;
      if ({wave_out[0], period_tick[0]} !== {1'b0, t > 0}) $display("FAIL rst_pend_after t=%0d wave_tick=%b exp=%b", t, {wave_out[0], period_tick[0]}, {1'b0, t > 0});
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_random();
    int burst_n[NCH];
    int ch;
    logic exp_ready;
    do_reset();
    for (int c = 0; c < NCH; c++) begin
      burst_n[c] = BURST_ON ? $urandom_range(0, 3) : $urandom_range(0, 255);
      cfg_write(c, $urandom_range(0, 12), $urandom_range(0, 14), $urandom_range(0, 14), burst_n[c]);
    end
    enable = NCH'($urandom_range(0, (1 << NCH) - 1));
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(0, 39) == 0) begin
        ch = $urandom_range(0, NCH - 1);
        enable[ch] = ~enable[ch];
      end
      sync_start = ($urandom_range(0, 49) == 0);
      ch = $urandom_range(0, 3);
      cfg_drive(ch, $urandom_range(0, 12), $urandom_range(0, 14), $urandom_range(0, 14),
                (ch < NCH) ? burst_n[ch] : $urandom_range(0, 255));
      cfg_if.cfg_valid = ($urandom_range(0, 7) == 0);
      #1;
      exp_ready = (ch >= NCH) ? 1'b1 : !m_pend[ch];
      check_cnt++;
      if (cfg_if.cfg_ready !== exp_ready) $display("FAIL rand_ready cyc=%0d ch=%0d got=%b exp=%b", cyc, ch, cfg_if.cfg_ready, exp_ready);
      else pass_cnt++;
      step();
      check_cnt++;
      if ({wave_out, period_tick, done} !== {exp_wave, exp_tick, exp_done})
        $display("FAIL rand_out cyc=%0d wave_tick_done=%b exp=%b", cyc, {wave_out, period_tick, done}, {exp_wave, exp_tick, exp_done});
      else pass_cnt++;
    end
    cfg_if.cfg_valid = 1'b0;
    sync_start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    enable = '0;
    sync_start = 1'b0;
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_ch     = '0;
    cfg_if.cfg_period = '0;
    cfg_if.cfg_high   = '0;
    cfg_if.cfg_phase  = '0;
    cfg_if.cfg_burst  = '0;
    test_reset();
    test_basic();
    test_midrun_write();
    test_sync_phase();
    test_boundary();
    test_phase_clamp();
`ifdef WAVE_GEN_BURST_EN
    test_burst();
`else
    test_no_burst();
`endif
    test_reset_pending();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
